// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - SD SPI-mode command constants, R1 helpers and responder FSM states
package sd_pkg;

    localparam logic [5:0] SD_CMD0  = 6'd0;
    localparam logic [5:0] SD_CMD8  = 6'd8;
    localparam logic [5:0] SD_CMD17 = 6'd17;
    localparam logic [5:0] SD_CMD41 = 6'd41;
    localparam logic [5:0] SD_CMD55 = 6'd55;
    localparam logic [5:0] SD_CMD58 = 6'd58;

    localparam int SD_R1_IDLE    = 0;
    localparam int SD_R1_ILLEGAL = 2;

    localparam logic [7:0]  SD_TOKEN_START = 8'hFE;
    localparam logic [31:0] SD_OCR         = 32'hC0FF_8000;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ARG,
        ST_NCR,
        ST_RESP,
        ST_NAC,
        ST_TOKEN,
        ST_DATA,
        ST_CRC
    } sd_state_t;

    function automatic logic [7:0] r1_byte(input logic idle, input logic illegal);
        logic [7:0] r1;
        r1 = 8'h00;
        r1[SD_R1_IDLE]    = idle;
        r1[SD_R1_ILLEGAL] = illegal;
        return r1;
    endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// rtl/sd_spi_byte.sv - oversampled SPI mode-0 target byte engine (sync, edge detect, rx/tx shift)
module sd_spi_byte (
    input  logic       clock,
    input  logic       reset,
    input  logic       spi_cs,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       cs_active,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    input  logic [7:0] tx_byte
);

    logic [1:0] cs_sync;
    logic [1:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic       sclk_q;
    logic       cs_q;
    logic [6:0] rx_sr;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sr;
    logic       load_pending;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_fall;

    assign cs_active = ~cs_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_q;
    assign sclk_fall = ~sclk_sync[1] & sclk_q;
    assign cs_fall   = cs_q & ~cs_sync[1];
    assign rx_valid  = cs_active & sclk_rise & (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sr, mosi_sync[1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            cs_sync      <= 2'b11;
            sclk_sync    <= 2'b00;
            mosi_sync    <= 2'b11;
            sclk_q       <= 1'b0;
            cs_q         <= 1'b1;
            rx_sr        <= 7'd0;
            bit_cnt      <= 3'd0;
            tx_sr        <= 8'hFF;
            load_pending <= 1'b0;
            spi_miso     <= 1'b1;
        end else begin
            cs_sync   <= {cs_sync[0], spi_cs};
            sclk_sync <= {sclk_sync[0], spi_sclk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_q    <= sclk_sync[1];
            cs_q      <= cs_sync[1];
            // Deselect or a fresh select restarts byte alignment and drives bit 7 of 0xFF.
            if (!cs_active || cs_fall) begin
                bit_cnt      <= 3'd0;
                load_pending <= 1'b0;
                tx_sr        <= 8'hFF;
                spi_miso     <= 1'b1;
            end else begin
                if (sclk_rise) begin
                    rx_sr   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        load_pending <= 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (load_pending) begin
                        spi_miso     <= tx_byte[7];
                        tx_sr        <= {tx_byte[6:0], 1'b1};
                        load_pending <= 1'b0;
                    end else begin
                        spi_miso <= tx_sr[7];
                        tx_sr    <= {tx_sr[6:0], 1'b1};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sdcard_spi_target.sv
// rtl/sdcard_spi_target.sv - SPI-mode SD card responder with single-sector read from a byte store
module sdcard_spi_target
    import sd_pkg::*;
#(
    parameter int ACMD41_BUSY = 2,
    parameter int READ_NAC    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_cs,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [31:0] rd_lba,
    output logic [8:0]  rd_idx,
    input  logic [7:0]  rd_data,
    output logic        card_ready
);

    localparam logic [15:0] BUSY_CNT = 16'(ACMD41_BUSY);
    localparam logic [15:0] NAC_LAST = 16'(READ_NAC - 1);

    sd_state_t   state;
    sd_state_t   state_next;
    logic        cs_active;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic [7:0]  tx_next;
    logic        tx_load;
    logic [5:0]  cmd_idx;
    logic [2:0]  arg_cnt;
    logic [31:0] arg_sr;
    logic [39:0] resp_sr;
    logic [2:0]  resp_left;
    logic        is_read;
    logic [15:0] nac_cnt;
    logic        crc_cnt;
    logic [1:0]  fetch_cnt;
    logic        card_idle;
    logic        app_flag;
    logic [15:0] acmd_cnt;
    logic        frame_start;
    logic        last_data;

    logic [7:0]  dec_r1;
    logic [31:0] dec_tail;
    logic [2:0]  dec_left;
    logic        dec_read;
    logic        dec_idle;
    logic [15:0] dec_acmd;
    logic        dec_app;

    sd_spi_byte u_byte (
        .clock     (clock),
        .reset     (reset),
        .spi_cs    (spi_cs),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .cs_active (cs_active),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_byte   (tx_byte)
    );

    assign frame_start = (rx_byte[7:6] == 2'b01);
    assign last_data   = (rd_idx == 9'd511);
    assign card_ready  = ~card_idle;

    // Response and card-state effects of the command held in cmd_idx/arg_sr.
    always_comb begin
        dec_r1   = r1_byte(card_idle, 1'b0);
        dec_tail = 32'h0;
        dec_left = 3'd0;
        dec_read = 1'b0;
        dec_idle = card_idle;
        dec_acmd = acmd_cnt;
        dec_app  = 1'b0;
        case (cmd_idx)
            SD_CMD0: begin
                dec_r1   = r1_byte(1'b1, 1'b0);
                dec_idle = 1'b1;
                dec_acmd = 16'd0;
            end
            SD_CMD8: begin
                dec_tail = {16'h0000, 8'h01, arg_sr[7:0]};
                dec_left = 3'd4;
            end
            SD_CMD55: dec_app = 1'b1;
            SD_CMD41: begin
                if (!app_flag) begin
                    dec_r1 = r1_byte(card_idle, 1'b1);
                end else if (acmd_cnt < BUSY_CNT) begin
                    dec_r1   = r1_byte(1'b1, 1'b0);
                    dec_acmd = acmd_cnt + 16'd1;
                end else begin
                    dec_r1   = r1_byte(1'b0, 1'b0);
                    dec_idle = 1'b0;
                end
            end
            SD_CMD58: begin
                dec_tail = SD_OCR;
                dec_left = 3'd4;
            end
            SD_CMD17: begin
                if (card_idle) begin
                    dec_r1 = r1_byte(1'b1, 1'b1);
                end else begin
                    dec_read = 1'b1;
                end
            end
            default: dec_r1 = r1_byte(card_idle, 1'b1);
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!cs_active) begin
            state_next = ST_HUNT;
        end else if (rx_valid) begin
            case (state)
                ST_HUNT:  if (frame_start) state_next = ST_ARG;
                ST_ARG:   if (arg_cnt == 3'd4) state_next = ST_NCR;
                ST_NCR:   state_next = ST_RESP;
                ST_RESP: begin
                    if (resp_left == 3'd0) begin
                        if (!is_read) begin
                            state_next = ST_HUNT;
                        end else if (READ_NAC == 0) begin
                            state_next = ST_TOKEN;
                        end else begin
                            state_next = ST_NAC;
                        end
                    end
                end
                ST_NAC:   if (nac_cnt == NAC_LAST) state_next = ST_TOKEN;
                ST_TOKEN: state_next = ST_DATA;
                ST_DATA:  if (last_data) state_next = ST_CRC;
                ST_CRC:   if (crc_cnt) state_next = ST_HUNT;
                default:  state_next = ST_HUNT;
            endcase
        end
    end

    // Byte for the next slot; mid-sector bytes come from the delayed fetch instead.
    always_comb begin
        tx_load = rx_valid;
        tx_next = 8'hFF;
        case (state)
            ST_NCR:   tx_next = resp_sr[39:32];
            ST_RESP: begin
                if (resp_left != 3'd0) begin
                    tx_next = resp_sr[31:24];
                end else if (state_next == ST_TOKEN) begin
                    tx_next = SD_TOKEN_START;
                end
            end
            ST_NAC:   if (state_next == ST_TOKEN) tx_next = SD_TOKEN_START;
            ST_TOKEN: tx_next = rd_data;
            ST_DATA:  tx_load = rx_valid && last_data;
            default:  tx_next = 8'hFF;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_idx   <= 6'd0;
            arg_cnt   <= 3'd0;
            arg_sr    <= 32'd0;
            resp_sr   <= 40'd0;
            resp_left <= 3'd0;
            is_read   <= 1'b0;
            nac_cnt   <= 16'd0;
            crc_cnt   <= 1'b0;
            fetch_cnt <= 2'd0;
            card_idle <= 1'b1;
            app_flag  <= 1'b0;
            acmd_cnt  <= 16'd0;
            rd_lba    <= 32'd0;
            rd_idx    <= 9'd0;
            tx_byte   <= 8'hFF;
        end else begin
            if (fetch_cnt != 2'd0) begin
                fetch_cnt <= fetch_cnt - 2'd1;
            end
            if (!cs_active) begin
                tx_byte <= 8'hFF;
            end else if (tx_load) begin
                tx_byte <= tx_next;
            end else if (fetch_cnt == 2'd1) begin
                tx_byte <= rd_data;
            end
            if (!cs_active) begin
                rd_idx    <= 9'd0;
                fetch_cnt <= 2'd0;
            end else if (rx_valid) begin
                case (state)
                    ST_HUNT: begin
                        if (frame_start) begin
                            cmd_idx <= rx_byte[5:0];
                            arg_cnt <= 3'd0;
                        end
                    end
                    ST_ARG: begin
                        if (arg_cnt == 3'd4) begin
                            resp_sr   <= {dec_r1, dec_tail};
                            resp_left <= dec_left;
                            is_read   <= dec_read;
                            card_idle <= dec_idle;
                            acmd_cnt  <= dec_acmd;
                            app_flag  <= dec_app;
                            if (dec_read) begin
                                rd_lba <= arg_sr;
                            end
                        end else begin
                            arg_sr  <= {arg_sr[23:0], rx_byte};
                            arg_cnt <= arg_cnt + 3'd1;
                        end
                    end
                    ST_RESP: begin
                        resp_sr <= {resp_sr[31:0], 8'h00};
                        nac_cnt <= 16'd0;
                        if (resp_left != 3'd0) begin
                            resp_left <= resp_left - 3'd1;
                        end
                    end
                    ST_NAC:   nac_cnt <= nac_cnt + 16'd1;
                    ST_TOKEN: crc_cnt <= 1'b0;
                    // Three clocks give the store two full clocks to follow rd_idx.
                    ST_DATA: begin
                        if (last_data) begin
                            rd_idx <= 9'd0;
                        end else begin
                            rd_idx    <= rd_idx + 9'd1;
                            fetch_cnt <= 2'd3;
                        end
                    end
                    ST_CRC:   crc_cnt <= 1'b1;
                    default:  crc_cnt <= crc_cnt;
                endcase
            end
        end
    end

endmodule
